// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: instruction-fetch sequencer.
// Owns the word-addressed PC, runs a req/ack handshake to instruction memory,
// holds each fetched instruction until downstream consumes it, then picks the
// next PC (sequential, taken branch or jump). A watchdog on the handshake
// parks the block in a sticky error state that only reset can leave.
module ifu_fetch_ctrl #(
    parameter int                ADDR_W   = 30,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                TIMEOUT  = 16
) (
    input  logic              clock,
    input  logic              start,
    input  logic              run,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic [25:0]       jump_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err,
    output logic [31:0]       fetch_count
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_HOLD  = 2'b10,
        S_ERR   = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_consume;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic [31:0]       r_fetch_count;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_next_pc;

    // Next-state decode; the consume strobe only exists in HOLD.
    always_comb begin
        w_state_nxt = r_state;
        w_consume   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_state_nxt = S_HOLD;
                end else if (r_wait_cnt == CNT_LAST) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_consume   = 1'b1;
                    w_state_nxt = run ? S_FETCH : S_IDLE;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_ERR;
            end
        endcase
    end

    // Next-PC select: jump beats taken branch beats sequential; all modulo 2^ADDR_W.
    always_comb begin
        w_pc_seq = r_pc + PC_ONE;
        if (jump) begin
            w_next_pc = {r_pc[ADDR_W-1:26], jump_target};
        end else if (branch && zero) begin
            w_next_pc = w_pc_seq + br_offset;
        end else begin
            w_next_pc = w_pc_seq;
        end
    end

    // State register and fetch datapath with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!start) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_pc          <= RESET_PC;
            r_inst        <= 32'h0000_0000;
            r_fetch_count <= 32'h0000_0000;
            r_wait_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    r_wait_cnt <= {CNT_W{1'b0}};
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_inst <= imem_rdata;
                        r_pc   <= r_fetch_pc;
                    end else if (r_wait_cnt != CNT_LAST) begin
                        r_wait_cnt <= r_wait_cnt + CNT_ONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt;
                    end
                end
                S_HOLD: begin
                    if (w_consume) begin
                        r_fetch_count <= r_fetch_count + 32'd1;
                        r_fetch_pc    <= w_next_pc;
                        r_wait_cnt    <= {CNT_W{1'b0}};
                    end else begin
                        r_fetch_count <= r_fetch_count;
                    end
                end
                S_ERR: begin
                    r_wait_cnt <= r_wait_cnt;
                end
                default: begin
                    r_wait_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state and registered data.
    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_fetch_pc;
    assign inst_valid  = (r_state == S_HOLD);
    assign fetch_err   = (r_state == S_ERR);
    assign inst        = r_inst;
    assign pc          = r_pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed self-checking bench for ifu_fetch_ctrl.
module tb_ifu_fetch_ctrl;
    localparam int AW = 30;

    logic          clock = 1'b0;
    logic          start = 1'b0;
    logic          run = 1'b0, stall = 1'b0, branch = 1'b0, zero = 1'b0, jump = 1'b0;
    logic          imem_ack = 1'b0;
    logic [AW-1:0] br_offset = '0;
    logic [25:0]   jump_target = '0;
    logic [31:0]   imem_rdata;
    logic          imem_req, inst_valid, fetch_err;
    logic [AW-1:0] imem_addr, pc;
    logic [31:0]   inst, fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(30'h0), .TIMEOUT(16)) dut (
        .clock(clock), .start(start), .run(run), .stall(stall),
        .branch(branch), .zero(zero), .jump(jump),
        .br_offset(br_offset), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .pc(pc),
        .fetch_err(fetch_err), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    // Memory model: instruction word is a fixed scramble of its address.
    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {2'b01, a} ^ 32'h5A5A_0F0F;
    endfunction
    assign imem_rdata = mem_word(imem_addr);

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_dec;
        branch = 1'b0; zero = 1'b0; jump = 1'b0;
        br_offset = '0; jump_target = '0;
    endtask

    task automatic do_reset;
        start = 1'b0; run = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        clear_dec();
        tick();
        start = 1'b1;
    endtask

    task automatic test_reset;
        start = 1'b0; run = 1'b1; imem_ack = 1'b1; stall = 1'b0; clear_dec();
        tick();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", fetch_err); end
        n_tests++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", fetch_count); end
        n_tests++; if (pc !== 30'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", pc); end
        n_tests++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", inst); end
        n_tests++; if (imem_addr !== 30'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        start = 1'b1; run = 1'b0;
        tick();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_noreq: got %b want 0", imem_req); end
        run = 1'b1;
        tick();
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL run_req: got %b want 1", imem_req); end
    endtask

    task automatic test_sequential;
        do_reset();
        run = 1'b1; imem_ack = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== AW'(i)) begin n_fail++; $display("FAIL seq_addr%0d: got req=%b addr=%h want 1/%h", i, imem_req, imem_addr, i); end
            n_tests++; if (fetch_count !== 32'(i)) begin n_fail++; $display("FAIL seq_count%0d: got %0d want %0d", i, fetch_count, i); end
            tick();
            n_tests++; if (inst_valid !== 1'b1 || imem_req !== 1'b0 || pc !== AW'(i)) begin n_fail++; $display("FAIL seq_hold%0d: got v=%b req=%b pc=%h", i, inst_valid, imem_req, pc); end
            n_tests++; if (inst !== mem_word(AW'(i))) begin n_fail++; $display("FAIL seq_inst%0d: got %h want %h", i, inst, mem_word(AW'(i))); end
            tick();
        end
        n_tests++; if (fetch_count !== 32'd4 || imem_addr !== 30'h4) begin n_fail++; $display("FAIL seq_end: got cnt=%0d addr=%h want 4/4", fetch_count, imem_addr); end
    endtask

    task automatic test_branch;
        do_reset();
        run = 1'b1; imem_ack = 1'b1;
        tick(); tick();
        jump = 1'b1; jump_target = 26'h5;
        tick(); clear_dec(); tick();
        n_tests++; if (pc !== 30'h5 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL br_setup: got pc=%h v=%b want 5/1", pc, inst_valid); end
        branch = 1'b1; zero = 1'b1; br_offset = 30'h3FFF_FFFC;
        tick();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 30'h2) begin n_fail++; $display("FAIL br_taken: got req=%b addr=%h want 1/2", imem_req, imem_addr); end
        clear_dec(); tick();
        n_tests++; if (pc !== 30'h2 || inst !== mem_word(30'h2)) begin n_fail++; $display("FAIL br_target_inst: got pc=%h inst=%h", pc, inst); end
        jump = 1'b1; jump_target = 26'h5;
        tick(); clear_dec(); tick();
        branch = 1'b1; zero = 1'b0; br_offset = 30'h3FFF_FFFC;
        tick();
        n_tests++; if (imem_addr !== 30'h6) begin n_fail++; $display("FAIL br_not_taken: got %h want 6", imem_addr); end
        clear_dec();
    endtask

    task automatic test_jump;
        do_reset();
        run = 1'b1; imem_ack = 1'b1;
        tick(); tick();
        branch = 1'b1; zero = 1'b1; br_offset = 30'h3000_000F;
        tick();
        n_tests++; if (imem_addr !== 30'h3000_0010) begin n_fail++; $display("FAIL jmp_setup: got %h want 30000010", imem_addr); end
        clear_dec(); tick();
        n_tests++; if (pc !== 30'h3000_0010) begin n_fail++; $display("FAIL jmp_pc: got %h want 30000010", pc); end
        jump = 1'b1; branch = 1'b1; zero = 1'b1; jump_target = 26'h123; br_offset = 30'h10;
        tick();
        n_tests++; if (imem_addr !== 30'h3000_0123) begin n_fail++; $display("FAIL jmp_over_br: got %h want 30000123", imem_addr); end
        clear_dec(); tick();
        n_tests++; if (pc !== 30'h3000_0123 || inst !== mem_word(30'h3000_0123)) begin n_fail++; $display("FAIL jmp_inst: got pc=%h inst=%h", pc, inst); end
    endtask

    // Continues from test_jump: HOLD at 0x3000_0123 with two consumes done.
    task automatic test_stall;
        logic [AW-1:0] exp_pc;
        exp_pc = 30'h3000_0123;
        stall = 1'b1; imem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++; if (inst_valid !== 1'b1 || imem_req !== 1'b0 || pc !== exp_pc || inst !== mem_word(exp_pc) || fetch_count !== 32'd2) begin
                n_fail++; $display("FAIL stall%0d: got v=%b req=%b pc=%h inst=%h cnt=%0d", k, inst_valid, imem_req, pc, inst, fetch_count);
            end
        end
        stall = 1'b0;
        tick();
        imem_ack = 1'b0; stall = 1'b1;
        n_tests++; if (imem_req !== 1'b1 || inst_valid !== 1'b0 || fetch_count !== 32'd3 || imem_addr !== 30'h3000_0124) begin
            n_fail++; $display("FAIL stall_release: got req=%b v=%b cnt=%0d addr=%h", imem_req, inst_valid, fetch_count, imem_addr);
        end
        n_tests++; if (pc !== exp_pc || inst !== mem_word(exp_pc)) begin n_fail++; $display("FAIL stall_keep: got pc=%h inst=%h", pc, inst); end
        tick();
        n_tests++; if (fetch_count !== 32'd3 || imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_single: got cnt=%0d req=%b want 3/1", fetch_count, imem_req); end
        stall = 1'b0;
    endtask

    task automatic test_timeout;
        do_reset();
        run = 1'b1; imem_ack = 1'b0;
        tick();
        for (int k = 1; k < 16; k++) begin
            n_tests++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got req=%b err=%b", k, imem_req, fetch_err); end
            tick();
        end
        imem_ack = 1'b1;
        tick();
        n_tests++; if (inst_valid !== 1'b1 || fetch_err !== 1'b0 || pc !== 30'h0) begin n_fail++; $display("FAIL to_late_ack: got v=%b err=%b pc=%h", inst_valid, fetch_err, pc); end
        imem_ack = 1'b0; stall = 1'b0;
        tick();
        for (int k = 1; k < 16; k++) tick();
        n_tests++; if (fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 30'h1) begin n_fail++; $display("FAIL to_cycle16: got err=%b req=%b addr=%h", fetch_err, imem_req, imem_addr); end
        tick();
        n_tests++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL to_err: got err=%b req=%b v=%b", fetch_err, imem_req, inst_valid); end
        imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || fetch_count !== 32'd1) begin
                n_fail++; $display("FAIL to_sticky%0d: got err=%b req=%b v=%b cnt=%0d", k, fetch_err, imem_req, inst_valid, fetch_count);
            end
        end
        start = 1'b0;
        tick();
        n_tests++; if (fetch_err !== 1'b0 || fetch_count !== 32'd0 || pc !== 30'h0 || inst !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 30'h0) begin
            n_fail++; $display("FAIL to_reset: got err=%b cnt=%0d pc=%h inst=%h req=%b addr=%h", fetch_err, fetch_count, pc, inst, imem_req, imem_addr);
        end
        start = 1'b1;
        tick();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 30'h0) begin n_fail++; $display("FAIL to_resume: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        tick();
        n_tests++; if (inst_valid !== 1'b1 || inst !== mem_word(30'h0)) begin n_fail++; $display("FAIL to_resume_inst: got v=%b inst=%h", inst_valid, inst); end
    endtask

    task automatic test_midreset;
        do_reset();
        run = 1'b1; imem_ack = 1'b0;
        tick();
        start = 1'b0; imem_ack = 1'b1;
        tick();
        n_tests++; if (inst_valid !== 1'b0 || imem_req !== 1'b0 || inst !== 32'h0) begin n_fail++; $display("FAIL mid_reset: got v=%b req=%b inst=%h", inst_valid, imem_req, inst); end
        start = 1'b1; run = 1'b0;
        tick(); tick();
        n_tests++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got req=%b v=%b", imem_req, inst_valid); end
        run = 1'b1;
        tick(); tick();
        n_tests++; if (inst_valid !== 1'b1 || pc !== 30'h0) begin n_fail++; $display("FAIL mid_fetch: got v=%b pc=%h", inst_valid, pc); end
        run = 1'b0; stall = 1'b0;
        tick();
        n_tests++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || fetch_count !== 32'd1) begin n_fail++; $display("FAIL stop_consume: got req=%b v=%b cnt=%0d", imem_req, inst_valid, fetch_count); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || fetch_count !== 32'd1) begin n_fail++; $display("FAIL stop_idle%0d: got req=%b v=%b cnt=%0d", k, imem_req, inst_valid, fetch_count); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_timeout();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Multi-cycle fetch sequencer for the instruction-fetch datapath.
- Owns the word-addressed PC and runs a request/acknowledge handshake to instruction memory.
- Holds each fetched instruction until the downstream stage consumes it, then selects the next PC: sequential, taken branch, or jump.
- Watchdog on the memory handshake latches a sticky fault.

Parameters:
- ADDR_W, 30, word-address width; byte address is {pc, 2'b00}.
- RESET_PC, 0, word address fetched first after reset.
- TIMEOUT, 16, max consecutive FETCH cycles without imem_ack before fault (≥2).

Ports:
- clock  in  1  sole clock, rising edge.
- start  in  1  synchronous active-low reset, sampled on clock rising edge.
- run  in  1  fetch enable.
- stall  in  1  downstream not ready; the instruction is consumed on a cycle with inst_valid=1 and stall=0.
- branch  in  1  branch decode for the held instruction, valid on the consume cycle.
- zero  in  1  ALU zero flag, valid on the consume cycle.
- jump  in  1  jump decode, valid on the consume cycle.
- br_offset  in  ADDR_W  sign-extended word offset.
- jump_target  in  26  jump field, instr[25:0].
- imem_req  out  1  memory request.
- imem_addr  out  ADDR_W  request word address.
- imem_ack  in  1  memory data valid this cycle.
- imem_rdata  in  32  instruction word.
- inst  out  32  held instruction.
- inst_valid  out  1  inst/pc valid.
- pc  out  ADDR_W  word address of inst.
- fetch_err  out  1  sticky timeout fault.
- fetch_count  out  32  instructions consumed since reset.

Behaviour:
- Reset (start=0 at edge), regardless of state, including mid-handshake:
  - state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, inst=0.
  - inst_valid=0, imem_req=0, fetch_err=0, fetch_count=0, wait_cnt=0.
- States: IDLE, FETCH, HOLD, ERR. Outputs decode from registered state; no combinational input→output paths.
- imem_req = (state==FETCH). imem_addr = fetch_pc, held stable for the whole FETCH state.
- IDLE:
  - run=1 → FETCH, wait_cnt=0.
  - Otherwise stay. imem_ack is ignored.
- FETCH:
  - imem_ack=1 → inst<=imem_rdata, pc<=fetch_pc, inst_valid<=1, go HOLD.
  - No ack and wait_cnt==TIMEOUT-1 → ERR.
  - Otherwise wait_cnt++.
  - run dropping during FETCH does not abort the transaction.
- HOLD:
  - inst_valid=1; everything holds while stall=1.
  - On consume:
    - inst_valid<=0, fetch_count<=fetch_count+1 (wraps at 2^32).
    - fetch_pc<=next_pc.
    - run=1 → FETCH (wait_cnt=0); run=0 → IDLE.
  - pc and inst keep their last values after inst_valid falls.
- ERR:
  - fetch_err=1, imem_req=0, inst_valid=0.
  - Only reset exits this state.
- next_pc, evaluated on the consume cycle, in priority order:
  - jump=1 → {pc[ADDR_W-1:26], jump_target}. jump overrides branch.
  - branch&zero → pc+1+br_offset.
  - Otherwise pc+1.
  - All arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Latency and throughput:
  - run rises in IDLE → imem_req=1 the next cycle.
  - ack on cycle N → inst_valid=1 on cycle N+1.
  - Consume on cycle M → imem_req=1 with the new address on cycle M+1.
  - Peak rate is one instruction per 2 cycles with zero-wait memory.
- An ack with imem_req=0 is ignored in all states.

Test Plan:
- Reset, run=1, imem_ack tied 1, stall=0, all decodes 0 → imem_addr sequence 0,1,2,3 on alternate cycles; fetch_count=3 after third consume; inst matches imem_rdata.
- In HOLD at pc=5: branch=1, zero=1, br_offset=0x3FFFFFFC (-4) on consume → next imem_addr=2. Repeat with zero=0 → imem_addr=6.
- pc=0x3000_0010 (word), jump=1, branch=1, zero=1, jump_target=0x0000123 on consume → imem_addr=0x3000_0123; jump beats branch.
- stall=1 for 5 cycles in HOLD → inst, pc, inst_valid stable, no imem_req, fetch_count unchanged; stall=0 → single consume and single increment.
- Ack withheld, TIMEOUT=16 → ack on 16th FETCH cycle accepted normally; separate run with no ack → fetch_err=1 after 16 cycles, imem_req=0, ack then ignored; start=0 one cycle → all reset values, fetch resumes at RESET_PC.
- start=0 asserted mid-FETCH with ack arriving the same cycle → ack discarded, inst_valid=0, state IDLE; run=0 after consume → IDLE, no further requests.
